// File: rtl/cnn_layer_accel_result_packer_if.sv
// Result stream from the quad and packed-word stream to writeback.
// slave = packer side, master = producer/consumer side.
interface cnn_layer_accel_result_packer_if #(
    parameter int RESULT_WIDTH = 16,
    parameter int OUT_WIDTH    = 128
);
    localparam int LANES = OUT_WIDTH / RESULT_WIDTH;

    // Both streams: a beat transfers on a rising clk_core edge where valid
    // (result_valid/out_valid) and the matching accept/ready are both high;
    // the sender holds its data stable until that edge.
    logic                    result_valid;
    logic                    result_accept;
    logic [RESULT_WIDTH-1:0] result_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [OUT_WIDTH-1:0]    out_data;
    logic [LANES-1:0]        out_lane_mask;
    logic [9:0]              out_row;
    logic [9:0]              out_col_base;
    logic [6:0]              out_depth;
    logic                    out_last;

    modport slave (
        input  result_valid, result_data, out_ready,
        output result_accept, out_valid, out_data, out_lane_mask,
        output out_row, out_col_base, out_depth, out_last
    );

    modport master (
        output result_valid, result_data, out_ready,
        input  result_accept, out_valid, out_data, out_lane_mask,
        input  out_row, out_col_base, out_depth, out_last
    );
endinterface

// File: rtl/cnn_layer_accel_result_packer.sv
// Packs the 16-bit result stream into 128-bit words per output row,
// tagging each word with row/depth/column and flushing at every row end.
module cnn_layer_accel_result_packer #(
    parameter int RESULT_WIDTH = 16,
    parameter int OUT_WIDTH    = 128
) (
    input  logic       clk_core,
    input  logic       rst,
    input  logic       start,
    input  logic [9:0] num_output_cols_cfg,
    input  logic [9:0] num_output_rows_cfg,
    input  logic [6:0] num_kernel_cfg,
    output logic       busy,
    output logic       done,
    output logic [1:0] dbg_state,
    cnn_layer_accel_result_packer_if.slave bus
);
    localparam int LANES = OUT_WIDTH / RESULT_WIDTH;
    localparam int CW    = $clog2(LANES + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [9:0]           cols_q, cols_d, rows_q, rows_d;
    logic [6:0]           kern_q, kern_d;
    logic [9:0]           col_q, col_d, row_q, row_d;
    logic [6:0]           dep_q, dep_d;
    logic [OUT_WIDTH-1:0] buf_q, buf_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 closed_q, closed_d;
    logic [9:0]           tag_row_q, tag_row_d, tag_col_q, tag_col_d;
    logic [6:0]           tag_dep_q, tag_dep_d;
    logic                 tag_last_q, tag_last_d;
    logic                 ov_q, ov_d;
    logic [OUT_WIDTH-1:0] od_q, od_d;
    logic [LANES-1:0]     om_q, om_d;
    logic [9:0]           orow_q, orow_d, ocol_q, ocol_d;
    logic [6:0]           odep_q, odep_d;
    logic                 olast_q, olast_d;

    logic          out_free, accept, fire;
    logic          col_end, row_end, dep_end, at_last;
    logic [CW-1:0] lane;

    function automatic logic [LANES-1:0] mask_of(input logic [CW-1:0] n);
        for (int i = 0; i < LANES; i++) mask_of[i] = (CW'(i) < n);
    endfunction

    assign col_end  = (col_q == cols_q - 10'd1);
    assign row_end  = (row_q == rows_q - 10'd1);
    assign dep_end  = (dep_q == kern_q - 7'd1);
    assign at_last  = col_end && row_end && dep_end;
    assign out_free = !ov_q || bus.out_ready;
    // A closed buffer blocks new results unless it leaves this very cycle.
    assign accept   = (state_q == S_RUN) && (!closed_q || out_free);
    assign fire     = accept && bus.result_valid;

    always_comb begin
        state_d    = state_q;
        cols_d     = cols_q;
        rows_d     = rows_q;
        kern_d     = kern_q;
        col_d      = col_q;
        row_d      = row_q;
        dep_d      = dep_q;
        buf_d      = buf_q;
        cnt_d      = cnt_q;
        closed_d   = closed_q;
        tag_row_d  = tag_row_q;
        tag_col_d  = tag_col_q;
        tag_dep_d  = tag_dep_q;
        tag_last_d = tag_last_q;
        ov_d       = ov_q && !bus.out_ready;
        od_d       = od_q;
        om_d       = om_q;
        orow_d     = orow_q;
        ocol_d     = ocol_q;
        odep_d     = odep_q;
        olast_d    = olast_q;
        lane       = '0;

        if (closed_q && out_free) begin
            ov_d     = 1'b1;
            od_d     = buf_q;
            om_d     = mask_of(cnt_q);
            orow_d   = tag_row_q;
            ocol_d   = tag_col_q;
            odep_d   = tag_dep_q;
            olast_d  = tag_last_q;
            buf_d    = '0;
            cnt_d    = '0;
            closed_d = 1'b0;
        end

        if (fire) begin
            lane = cnt_d;
            for (int i = 0; i < LANES; i++)
                if (lane == CW'(i)) buf_d[i*RESULT_WIDTH +: RESULT_WIDTH] = bus.result_data;
            if (lane == '0) begin
                tag_row_d = row_q;
                tag_col_d = col_q;
                tag_dep_d = dep_q;
            end
            tag_last_d = at_last;
            cnt_d      = lane + CW'(1);
            if (lane == CW'(LANES - 1) || col_end) begin
                // Skip the buffer stage when the output register is free.
                if (!closed_q && out_free) begin
                    ov_d    = 1'b1;
                    od_d    = buf_d;
                    om_d    = mask_of(cnt_d);
                    orow_d  = tag_row_d;
                    ocol_d  = tag_col_d;
                    odep_d  = tag_dep_d;
                    olast_d = tag_last_d;
                    buf_d   = '0;
                    cnt_d   = '0;
                end else begin
                    closed_d = 1'b1;
                end
            end
            if (col_end) begin
                col_d = '0;
                if (row_end) begin
                    row_d = '0;
                    dep_d = dep_end ? 7'd0 : dep_q + 7'd1;
                end else begin
                    row_d = row_q + 10'd1;
                end
            end else begin
                col_d = col_q + 10'd1;
            end
            if (at_last) state_d = S_DRAIN;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cols_d  = num_output_cols_cfg;
                    rows_d  = num_output_rows_cfg;
                    kern_d  = num_kernel_cfg;
                    col_d   = '0;
                    row_d   = '0;
                    dep_d   = '0;
                    state_d = (num_output_cols_cfg == '0 || num_output_rows_cfg == '0 ||
                               num_kernel_cfg == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN:   ;
            S_DRAIN: if (ov_q && bus.out_ready && olast_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_core or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cols_q     <= '0;
            rows_q     <= '0;
            kern_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            dep_q      <= '0;
            buf_q      <= '0;
            cnt_q      <= '0;
            closed_q   <= 1'b0;
            tag_row_q  <= '0;
            tag_col_q  <= '0;
            tag_dep_q  <= '0;
            tag_last_q <= 1'b0;
            ov_q       <= 1'b0;
            od_q       <= '0;
            om_q       <= '0;
            orow_q     <= '0;
            ocol_q     <= '0;
            odep_q     <= '0;
            olast_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cols_q     <= cols_d;
            rows_q     <= rows_d;
            kern_q     <= kern_d;
            col_q      <= col_d;
            row_q      <= row_d;
            dep_q      <= dep_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            closed_q   <= closed_d;
            tag_row_q  <= tag_row_d;
            tag_col_q  <= tag_col_d;
            tag_dep_q  <= tag_dep_d;
            tag_last_q <= tag_last_d;
            ov_q       <= ov_d;
            od_q       <= od_d;
            om_q       <= om_d;
            orow_q     <= orow_d;
            ocol_q     <= ocol_d;
            odep_q     <= odep_d;
            olast_q    <= olast_d;
        end
    end

    assign busy              = (state_q != S_IDLE);
    assign done              = (state_q == S_DONE);
    assign dbg_state         = state_q;
    assign bus.result_accept = accept;
    assign bus.out_valid     = ov_q;
    assign bus.out_data      = od_q;
    assign bus.out_lane_mask = om_q;
    assign bus.out_row       = orow_q;
    assign bus.out_col_base  = ocol_q;
    assign bus.out_depth     = odep_q;
    assign bus.out_last      = olast_q;
endmodule
